// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the millennium clock: field indices of the counter
// chain, the RUN/SET mode encoding and small helpers for field selection.
// Used by set_mode_ctrl, btn_repeat and the counter/display blocks.
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int NUM_FIELDS = 6;

    localparam logic [2:0] FIELD_SEC   = 3'd0;
    localparam logic [2:0] FIELD_MIN   = 3'd1;
    localparam logic [2:0] FIELD_HOUR  = 3'd2;
    localparam logic [2:0] FIELD_DAY   = 3'd3;
    localparam logic [2:0] FIELD_MONTH = 3'd4;
    localparam logic [2:0] FIELD_YEAR  = 3'd5;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    // Field after f, wrapping from year back to seconds.
    function automatic logic [2:0] next_field(input logic [2:0] f);
        return (f == FIELD_YEAR) ? FIELD_SEC : f + 3'd1;
    endfunction

    // One-hot select for field f (bit i = field i).
    function automatic logic [NUM_FIELDS-1:0] field_onehot(input logic [2:0] f);
        logic [NUM_FIELDS-1:0] one;
        one = {{(NUM_FIELDS-1){1'b0}}, 1'b1};
        return one << f;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// -----------------------------------------------------------------------------
// btn_repeat
// Rising-edge detector plus optional hold/repeat timer for one direction
// button. Both outputs are single-cycle requests; the parent decides whether
// a request becomes a strobe.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   edge_en     0 in the first cycle after reset so a held button gives no edge
//   level       debounced button level
//   clr         drop any repeat in progress (also blocks arming on this edge)
//   btn_edge    level rose this cycle
//   rep_pulse   auto-repeat request (hold expired or repeat interval elapsed)
//
// Build option: AUTO_REPEAT_EN builds the hold/repeat timer; without it
// rep_pulse is tied low and no counters exist.
// -----------------------------------------------------------------------------
module btn_repeat
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic edge_en,
    input  logic level,
    input  logic clr,
    output logic btn_edge,
    output logic rep_pulse
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign btn_edge = edge_en & level & ~prev;

`ifdef AUTO_REPEAT_EN
    // cnt holds the number of cycles since the last strobe decision, so a
    // match against the limit in cycle N yields a strobe in cycle N+1.
    logic        active;
    logic        in_repeat;
    logic [31:0] cnt;
    logic [31:0] limit;

    assign limit = in_repeat ? 32'(REPEAT_CYCLES) : 32'(HOLD_CYCLES);

    // Not gated by clr: the parent gates it, and clr itself depends on
    // whether a strobe goes out this cycle.
    assign rep_pulse = active & level & (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            in_repeat <= 1'b0;
            cnt       <= 32'd0;
        end else if (clr || !level) begin
            active    <= 1'b0;
            in_repeat <= 1'b0;
            cnt       <= 32'd0;
        end else if (btn_edge) begin
            active    <= 1'b1;
            in_repeat <= 1'b0;
            cnt       <= 32'd1;
        end else if (active) begin
            if (cnt == limit) begin
                cnt       <= 32'd1;
                in_repeat <= 1'b1;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = clr ^ (HOLD_CYCLES == REPEAT_CYCLES);
    assign rep_pulse  = 1'b0;
`endif

endmodule

// File: rtl/set_mode_ctrl.sv
// -----------------------------------------------------------------------------
// set_mode_ctrl
// Time-setting controller for the sec/min/hour/day/month/year counter chain.
// A RUN/SET FSM driven by four debounced buttons selects one field, issues
// single-cycle inc/dec strobes to that field's counter and blinks its display.
//
// Handshake: there is no valid/ready pairing here. Buttons are levels; each
// accepted rising edge (or auto-repeat tick) produces exactly one cycle of
// inc or dec in the following cycle, and the counter must act on every
// strobe cycle. Within one cycle mode edge > next edge > up/down; a lower
// priority edge is discarded, never deferred.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   btn_mode     rising edge toggles RUN/SET
//   btn_next     rising edge advances the selected field (SET only)
//   btn_up       increment request (SET only)
//   btn_down     decrement request (SET only)
//   set_mode     1 while in SET
//   field_sel    selected field 0..5, 0 in RUN
//   ctrl_set     one-hot of field_sel in SET, 0 in RUN
//   inc, dec     one-cycle strobes, never together
//   blink        1 = selected field visible; 1 in RUN
//   dbg_state    current FSM state
//
// Build option: AUTO_REPEAT_EN enables hold-to-repeat on up/down.
// -----------------------------------------------------------------------------
module set_mode_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 25000000,
    parameter int unsigned REPEAT_CYCLES  = 5000000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned BLINK_CYCLES   = 12500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_mode,
    input  logic                  btn_next,
    input  logic                  btn_up,
    input  logic                  btn_down,
    output logic                  set_mode,
    output logic [2:0]            field_sel,
    output logic [NUM_FIELDS-1:0] ctrl_set,
    output logic                  inc,
    output logic                  dec,
    output logic                  blink,
    output state_t                dbg_state
);

    state_t      state;
    logic        edge_en;
    logic        mode_prev;
    logic        next_prev;
    logic [31:0] tmo_cnt;
    logic [31:0] blink_cnt;

    logic mode_e;
    logic next_e;
    logic up_e;
    logic down_e;
    logic up_rep;
    logic down_rep;
    logic in_set;
    logic both_held;
    logic inc_req;
    logic dec_req;
    logic strobe_req;
    logic tmo_exit;
    logic rep_clr;

    assign mode_e = edge_en & btn_mode & ~mode_prev;
    assign next_e = edge_en & btn_next & ~next_prev;

    assign in_set    = (state == ST_SET);
    assign both_held = btn_up & btn_down;

    // A direction request only becomes a strobe when no higher-priority edge
    // is present and the opposite button is released.
    assign inc_req    = in_set & ~mode_e & ~next_e & ~btn_down & (up_e | up_rep);
    assign dec_req    = in_set & ~mode_e & ~next_e & ~btn_up & (down_e | down_rep);
    assign strobe_req = inc_req | dec_req;

    assign tmo_exit = in_set & ~mode_e & ~next_e & ~up_e & ~down_e & ~strobe_req
                    & (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    assign rep_clr = ~in_set | mode_e | next_e | both_held | tmo_exit;

    btn_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_rep_up (
        .clk       (clk),
        .rst_n     (rst_n),
        .edge_en   (edge_en),
        .level     (btn_up),
        .clr       (rep_clr),
        .btn_edge  (up_e),
        .rep_pulse (up_rep)
    );

    btn_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_rep_down (
        .clk       (clk),
        .rst_n     (rst_n),
        .edge_en   (edge_en),
        .level     (btn_down),
        .clr       (rep_clr),
        .btn_edge  (down_e),
        .rep_pulse (down_rep)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            set_mode  <= 1'b0;
            field_sel <= FIELD_SEC;
            ctrl_set  <= '0;
            inc       <= 1'b0;
            dec       <= 1'b0;
            blink     <= 1'b1;
            tmo_cnt   <= 32'd0;
            blink_cnt <= 32'd0;
            edge_en   <= 1'b0;
            mode_prev <= 1'b0;
            next_prev <= 1'b0;
        end else begin
            // Edges are masked for one cycle after reset while the previous
            // registers pick up the real button levels.
            edge_en   <= 1'b1;
            mode_prev <= btn_mode;
            next_prev <= btn_next;
            inc       <= inc_req;
            dec       <= dec_req;

            case (state)
                ST_RUN: begin
                    set_mode  <= 1'b0;
                    field_sel <= FIELD_SEC;
                    ctrl_set  <= '0;
                    blink     <= 1'b1;
                    blink_cnt <= 32'd0;
                    tmo_cnt   <= 32'd0;
                    if (mode_e) begin
                        state    <= ST_SET;
                        set_mode <= 1'b1;
                        ctrl_set <= field_onehot(FIELD_SEC);
                    end
                end

                ST_SET: begin
                    if (mode_e || tmo_exit) begin
                        state     <= ST_RUN;
                        set_mode  <= 1'b0;
                        field_sel <= FIELD_SEC;
                        ctrl_set  <= '0;
                        blink     <= 1'b1;
                        blink_cnt <= 32'd0;
                        tmo_cnt   <= 32'd0;
                    end else begin
                        if (next_e || up_e || down_e || strobe_req) begin
                            tmo_cnt <= 32'd0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 32'd1;
                        end

                        if (next_e) begin
                            field_sel <= next_field(field_sel);
                            ctrl_set  <= field_onehot(next_field(field_sel));
                        end

                        // Restart the blink phase whenever the user touches
                        // the field so the new value is shown immediately.
                        if (next_e || strobe_req) begin
                            blink     <= 1'b1;
                            blink_cnt <= 32'd0;
                        end else if (blink_cnt == 32'(BLINK_CYCLES - 1)) begin
                            blink     <= ~blink;
                            blink_cnt <= 32'd0;
                        end else begin
                            blink_cnt <= blink_cnt + 32'd1;
                        end
                    end
                end

                default: state <= ST_RUN;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_set_mode_ctrl
// Directed bench for set_mode_ctrl with HOLD=8, REPEAT=4, TIMEOUT=64,
// BLINK=16. Inputs change 1 ns after a rising edge and outputs are read at
// the same point, i.e. after the registers have updated.
// -----------------------------------------------------------------------------
module tb_set_mode_ctrl;
  import clock_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic btn_mode, btn_next, btn_up, btn_down;
  logic set_mode;
  logic [2:0] field_sel;
  logic [5:0] ctrl_set;
  logic inc, dec, blink;
  state_t dbg_state;

  int checks = 0;
  int failures = 0;
  logic [0:0] exp_q[$];
  logic [31:0] rep_mask;
  logic [0:0] exp_bit;
  int inc_seen;

  always #5 clk = ~clk;

  set_mode_ctrl #(
    .HOLD_CYCLES(8),
    .REPEAT_CYCLES(4),
    .TIMEOUT_CYCLES(64),
    .BLINK_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_mode(btn_mode),
    .btn_next(btn_next),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .set_mode(set_mode),
    .field_sel(field_sel),
    .ctrl_set(ctrl_set),
    .inc(inc),
    .dec(dec),
    .blink(blink),
    .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    tick(1);
    btn_mode = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    btn_mode = 1'b0;
    btn_next = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(3);

    // reset values
    check("rst_set_mode", set_mode, 0);
    check("rst_field", field_sel, 0);
    check("rst_ctrl", ctrl_set, 0);
    check("rst_inc", inc, 0);
    check("rst_dec", dec, 0);
    check("rst_blink", blink, 1);
    check("rst_state", dbg_state, ST_RUN);
    rst_n = 1'b1;
    tick(3);

    // 1: enter SET
    btn_mode = 1'b1;
    tick(1);
    check("enter_set_mode", set_mode, 1);
    check("enter_field", field_sel, 0);
    check("enter_ctrl", ctrl_set, 6'b000001);
    check("enter_blink", blink, 1);
    check("enter_state", dbg_state, ST_SET);
    btn_mode = 1'b0;
    tick(1);

    // 2: six next edges walk the fields and wrap
    btn_next = 1'b1; tick(1); check("next1_field", field_sel, 1); check("next1_ctrl", ctrl_set, 6'b000010);
    btn_next = 1'b0; tick(1);
    btn_next = 1'b1; tick(1); check("next2_field", field_sel, 2); check("next2_ctrl", ctrl_set, 6'b000100);
    btn_next = 1'b0; tick(1);
    btn_next = 1'b1; tick(1); check("next3_field", field_sel, 3); check("next3_ctrl", ctrl_set, 6'b001000);
    btn_next = 1'b0; tick(1);
    btn_next = 1'b1; tick(1); check("next4_field", field_sel, 4); check("next4_ctrl", ctrl_set, 6'b010000);
    btn_next = 1'b0; tick(1);
    btn_next = 1'b1; tick(1); check("next5_field", field_sel, 5); check("next5_ctrl", ctrl_set, 6'b100000);
    btn_next = 1'b0; tick(1);
    btn_next = 1'b1; tick(1); check("next6_field", field_sel, 0); check("next6_ctrl", ctrl_set, 6'b000001);
    btn_next = 1'b0; tick(1);
    press_mode();
    check("exit_set_mode", set_mode, 0);
    check("exit_ctrl", ctrl_set, 0);
    check("exit_field", field_sel, 0);
    tick(1);

    // 3: up in RUN ignored; single press in SET gives one inc
    btn_up = 1'b1; tick(1); check("run_up_inc", inc, 0);
    btn_up = 1'b0; tick(1); check("run_up_inc2", inc, 0);
    press_mode();
    tick(1);
    btn_up = 1'b1; tick(1);
    check("up_inc", inc, 1);
    check("up_dec", dec, 0);
    check("up_blink", blink, 1);
    btn_up = 1'b0; tick(1);
    check("up_inc_end", inc, 0);
    inc_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (inc) inc_seen++;
    end
    check("up_no_extra", inc_seen, 0);
    btn_down = 1'b1; tick(1);
    check("down_dec", dec, 1);
    check("down_inc", inc, 0);
    btn_down = 1'b0; tick(1);
    check("down_dec_end", dec, 0);

    // 4: simultaneous up/down, then next coincident with up
    btn_up = 1'b1; btn_down = 1'b1; tick(1);
    check("both_inc", inc, 0);
    check("both_dec", dec, 0);
    tick(1);
    check("both_inc2", inc, 0);
    check("both_dec2", dec, 0);
    btn_up = 1'b0; btn_down = 1'b0; tick(1);
    btn_next = 1'b1; btn_up = 1'b1; tick(1);
    check("nextup_field", field_sel, 1);
    check("nextup_ctrl", ctrl_set, 6'b000010);
    check("nextup_inc", inc, 0);
    btn_next = 1'b0; btn_up = 1'b0; tick(1);
    check("nextup_inc2", inc, 0);
    press_mode();
    check("exit2_field", field_sel, 0);
    check("exit2_set_mode", set_mode, 0);
    check("exit2_ctrl", ctrl_set, 0);
    tick(1);
    // mode and next together: mode wins, next discarded
    btn_mode = 1'b1; btn_next = 1'b1; tick(1);
    check("modenext_set", set_mode, 1);
    check("modenext_field", field_sel, 0);
    btn_mode = 1'b0; btn_next = 1'b0; tick(1);

    // 5: up held 30 cycles
`ifdef AUTO_REPEAT_EN
    rep_mask = 32'h22222202;
`else
    rep_mask = 32'h00000002;
`endif
    for (int k = 1; k <= 30; k++) exp_q.push_back(rep_mask[k]);
    btn_up = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      exp_bit = exp_q.pop_front();
      check($sformatf("hold_inc_%0d", k), inc, exp_bit);
    end
    btn_up = 1'b0;
    inc_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (inc) inc_seen++;
    end
    check("hold_release_inc", inc_seen, 0);
    press_mode();
    check("exit3_set_mode", set_mode, 0);
    tick(1);

    // 6a: idle timeout and blink phase
    press_mode();
    check("tmo_enter", set_mode, 1);
    for (int c = 2; c <= 65; c++) begin
      tick(1);
      if (c == 16) check("blink_c16", blink, 1);
      if (c == 17) check("blink_c17", blink, 0);
      if (c == 32) check("blink_c32", blink, 0);
      if (c == 33) check("blink_c33", blink, 1);
      if (c == 64) check("tmo_c64", set_mode, 1);
      if (c == 65) check("tmo_c65", set_mode, 0);
    end
    check("tmo_state", dbg_state, ST_RUN);
    check("tmo_blink", blink, 1);

    // 6b: reset mid-SET while up is held
    press_mode();
    btn_up = 1'b1; tick(1);
    check("pre_rst_inc", inc, 1);
    tick(2);
    rst_n = 1'b0;
    #2;
    check("arst_set_mode", set_mode, 0);
    check("arst_ctrl", ctrl_set, 0);
    check("arst_inc", inc, 0);
    check("arst_blink", blink, 1);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    press_mode();
    check("held_set", set_mode, 1);
    inc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (inc) inc_seen++;
    end
    check("held_no_inc", inc_seen, 0);
    btn_up = 1'b0; tick(1);
    btn_up = 1'b1; tick(1);
    check("repress_inc", inc, 1);
    btn_up = 1'b0; tick(2);

    // 7: mode held through reset release gives no edge
    btn_mode = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("held_mode_run", set_mode, 0);
    btn_mode = 1'b0; tick(1);
    btn_mode = 1'b1; tick(1);
    check("repress_mode", set_mode, 1);
    btn_mode = 1'b0; tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
